// File: rtl/hv_fetch_pkg.sv
// Shared types for the item-memory index fetcher: FSM state encoding and word geometry helper.
// Pure declarations; no logic, no latency, no flow control.
package hv_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    STREAM = 2'd3
  } state_e;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/im_word_unpacker.sv
// Holds one fetched memory word and walks its packed index slots LSB-first.
// Load/advance take effect on the next edge; idx_o/last_o come straight from flops.
module im_word_unpacker
  import hv_fetch_pkg::*;
#(
  parameter int DataWidth   = 32,
  parameter int IdxWidth    = 16,
  parameter int ImAddrWidth = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   load_i,
  input  logic [DataWidth-1:0]   data_i,
  input  logic                   advance_i,
  output logic [ImAddrWidth-1:0] idx_o,
  output logic                   last_o
);

  localparam int IdxPerWord = DataWidth / IdxWidth;
  localparam int SlotWidth  = (IdxPerWord > 1) ? $clog2(IdxPerWord) : 1;
  localparam logic [SlotWidth-1:0] LastSlot = SlotWidth'(IdxPerWord - 1);

  logic [DataWidth-1:0] r_word;
  logic [SlotWidth-1:0] r_slot;

  // Shifting the buffer keeps the current slot at bit 0, so no variable part-select is needed.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      r_word <= '0;
      r_slot <= '0;
    end else if (load_i) begin
      r_word <= data_i;
      r_slot <= '0;
    end else if (advance_i) begin
      r_word <= r_word >> IdxWidth;
      r_slot <= r_slot + 1'b1;
    end
  end

  assign idx_o  = r_word[ImAddrWidth-1:0];
  assign last_o = (r_slot == LastSlot);

endmodule

// File: rtl/im_index_fetcher.sv
// Streams packed item-memory indices from a read port, one index per valid/ready beat; start-to-request 1 cycle, response-to-index 1 cycle.
// Holds index stable under lowdim backpressure; optional stall counter under IM_INDEX_FETCHER_PERF_EN.
module im_index_fetcher
  import hv_fetch_pkg::*;
#(
  parameter int DataWidth   = 32,
  parameter int AddrWidth   = 32,
  parameter int IdxWidth    = 16,
  parameter int ImAddrWidth = 10,
  parameter int LenWidth    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   start_i,
  input  logic [AddrWidth-1:0]   base_addr_i,
  input  logic [LenWidth-1:0]    num_items_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [AddrWidth-1:0]   mem_req_addr_o,
  input  logic                   mem_rsp_valid_i,
  input  logic [DataWidth-1:0]   mem_rsp_data_i,
  output logic [ImAddrWidth-1:0] lowdim_o,
  output logic                   lowdim_valid_o,
  input  logic                   lowdim_ready_i,
  output logic [31:0]            stall_cnt_o
);

  localparam logic [AddrWidth-1:0] BytesPerWord = AddrWidth'(bytes_per_word(DataWidth));

  state_e               r_state;
  state_e               w_state_nxt;
  logic [AddrWidth-1:0] r_addr;
  logic [LenWidth-1:0]  r_remain;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 w_start_ok;
  logic                 w_nonzero;
  logic                 w_req_hs;
  logic                 w_load;
  logic                 w_idx_hs;
  logic                 w_last_slot;
  logic [ImAddrWidth-1:0] w_idx;

  assign w_start_ok = (r_state == IDLE) && start_i;
  assign w_nonzero  = (num_items_i != '0);
  assign w_req_hs   = (r_state == REQ) && mem_req_ready_i;
  assign w_load     = (r_state == WAIT) && mem_rsp_valid_i;
  assign w_idx_hs   = (r_state == STREAM) && lowdim_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          if (w_nonzero) w_state_nxt = REQ;
          else           w_done_nxt  = 1'b1;
        end
      end
      REQ:  if (mem_req_ready_i) w_state_nxt = WAIT;
      WAIT: if (mem_rsp_valid_i) w_state_nxt = STREAM;
      STREAM: begin
        if (lowdim_ready_i) begin
          if (r_remain == LenWidth'(1)) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else if (w_last_slot) begin
            w_state_nxt = REQ;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_start_ok && w_nonzero) begin
        r_addr   <= base_addr_i;
        r_remain <= num_items_i;
      end else begin
        if (w_req_hs) r_addr   <= r_addr + BytesPerWord;
        if (w_idx_hs) r_remain <= r_remain - 1'b1;
      end
    end
  end

  im_word_unpacker #(
    .DataWidth   (DataWidth),
    .IdxWidth    (IdxWidth),
    .ImAddrWidth (ImAddrWidth)
  ) u_unpacker (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (clr_i),
    .load_i    (w_load),
    .data_i    (mem_rsp_data_i),
    .advance_i (w_idx_hs),
    .idx_o     (w_idx),
    .last_o    (w_last_slot)
  );

  assign busy_o          = (r_state != IDLE);
  assign done_o          = r_done;
  assign mem_req_valid_o = (r_state == REQ);
  assign mem_req_addr_o  = r_addr;
  assign lowdim_valid_o  = (r_state == STREAM);
  // Masked outside STREAM so a stale word never shows on the index bus.
  assign lowdim_o        = lowdim_valid_o ? w_idx : '0;

`ifdef IM_INDEX_FETCHER_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i || w_start_ok) begin
      r_stall_cnt <= '0;
    end else if (lowdim_valid_o && !lowdim_ready_i && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
